// File: rtl/prog_inst_memory.sv
// Runtime-loadable instruction memory: combinational fetch port plus a valid/ready
// load port that rewrites the program while the CPU is held.
module prog_inst_memory #(
    parameter int                  DATA_W   = 16,
    parameter int                  ADDR_W   = 5,
    parameter int                  DEPTH    = 2**ADDR_W,
    parameter logic [DATA_W-1:0]   NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   prog_len
);

    typedef enum logic {RUN, LOAD} state_t;

    localparam int              LAST_INT = DEPTH - 1;
    localparam logic [ADDR_W:0] LAST_PTR = LAST_INT[ADDR_W:0];

    state_t            state;
    logic [ADDR_W:0]   wr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              beat;

    assign load_ready = (state == LOAD);
    assign cpu_hold   = (state == LOAD);

    // A restart pulse wins over a coincident data beat, which is dropped.
    assign beat = load_ready && load_valid && !load_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wr_ptr    <= '0;
            prog_len  <= '0;
            load_done <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                RUN: begin
                    if (load_start) begin
                        state    <= LOAD;
                        wr_ptr   <= '0;
                        prog_len <= '0;
                    end
                end
                LOAD: begin
                    if (load_start) begin
                        wr_ptr   <= '0;
                        prog_len <= '0;
                    end else if (beat) begin
                        wr_ptr   <= wr_ptr + 1'b1;
                        prog_len <= wr_ptr + 1'b1;
                        if (load_last || wr_ptr == LAST_PTR) begin
                            state     <= RUN;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // NOTE: the array has no reset; prog_len masks every unwritten word, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (beat)
            mem[wr_ptr[ADDR_W-1:0]] <= load_data;
    end

    // prog_len never exceeds DEPTH, so this also masks addresses beyond the array.
    always_comb begin
        instruction = NOP_WORD;
        if ({1'b0, address} < prog_len)
            instruction = mem[address];
    end

endmodule

// File: tb/tb_prog_inst_memory.sv
// Directed bench for prog_inst_memory: reset masking, normal, full, gapped,
// restarted and reset-interrupted loads.
module tb_prog_inst_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  address = '0;
    logic [15:0] instruction;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        cpu_hold;
    logic        load_done;
    logic [5:0]  prog_len;

    int tests_run = 0;
    int tests_failed = 0;

    prog_inst_memory dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .instruction (instruction),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .prog_len    (prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [4:0] a, input logic [15:0] exp);
        address = a;
        #1;
        check(tag, instruction, exp);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_prog_len", prog_len, 0);
        check("rst_cpu_hold", cpu_hold, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        for (int a = 0; a < 32; a++) fetch("rst_nop", 5'(a), 16'h0000);

        // load_valid in RUN is ignored
        beat(16'hffff, 1'b1);
        check("run_ignore_len", prog_len, 0);
        check("run_ignore_done", load_done, 0);

        // Three-word load
        start_load();
        check("l3_hold", cpu_hold, 1);
        check("l3_ready", load_ready, 1);
        beat(16'h2000, 1'b0);
        beat(16'h2011, 1'b0);
        check("l3_mid_len", prog_len, 2);
        check("l3_mid_hold", cpu_hold, 1);
        check("l3_mid_done", load_done, 0);
        fetch("l3_mid_a1", 5'd1, 16'h2011);
        fetch("l3_same_cycle", 5'd2, 16'h0000);
        beat(16'h3200, 1'b1);
        check("l3_done", load_done, 1);
        check("l3_len", prog_len, 3);
        check("l3_hold_off", cpu_hold, 0);
        fetch("l3_a2_after", 5'd2, 16'h3200);
        step();
        check("l3_done_once", load_done, 0);
        fetch("l3_a0", 5'd0, 16'h2000);
        fetch("l3_a1", 5'd1, 16'h2011);
        fetch("l3_a2", 5'd2, 16'h3200);
        fetch("l3_a3", 5'd3, 16'h0000);

        // Full load terminates by itself after 32 words
        start_load();
        check("full_restart_len", prog_len, 0);
        for (int i = 0; i < 31; i++) beat(16'h4000 + 16'(i), 1'b0);
        check("full_31_len", prog_len, 31);
        check("full_31_hold", cpu_hold, 1);
        check("full_31_done", load_done, 0);
        beat(16'h401f, 1'b0);
        check("full_done", load_done, 1);
        check("full_len", prog_len, 32);
        check("full_ready", load_ready, 0);
        beat(16'hdead, 1'b0);
        check("full_extra_len", prog_len, 32);
        check("full_extra_done", load_done, 0);
        check("full_extra_ready", load_ready, 0);
        fetch("full_a0", 5'd0, 16'h4000);
        fetch("full_a17", 5'd17, 16'h4011);
        fetch("full_a31", 5'd31, 16'h401f);

        // Gapped valid: only qualified beats land
        start_load();
        for (int i = 0; i < 4; i++) begin
            beat(16'h5000 + 16'(i * 17), i == 3);
            if (i == 3) check("gap_done", load_done, 1);
            else begin
                load_data = 16'hbad0;
                step();
                check("gap_idle_done", load_done, 0);
            end
        end
        check("gap_len", prog_len, 4);
        fetch("gap_a0", 5'd0, 16'h5000);
        fetch("gap_a1", 5'd1, 16'h5011);
        fetch("gap_a2", 5'd2, 16'h5022);
        fetch("gap_a3", 5'd3, 16'h5033);
        fetch("gap_a4", 5'd4, 16'h0000);

        // Restart mid-load; coincident beat is discarded
        start_load();
        beat(16'h6000, 1'b0);
        beat(16'h6001, 1'b0);
        load_start = 1'b1;
        beat(16'h6002, 1'b0);
        load_start = 1'b0;
        check("rs_len", prog_len, 0);
        check("rs_hold", cpu_hold, 1);
        check("rs_done", load_done, 0);
        beat(16'h7000, 1'b0);
        beat(16'h7001, 1'b1);
        check("rs_done_pulse", load_done, 1);
        check("rs_len_final", prog_len, 2);
        fetch("rs_a0", 5'd0, 16'h7000);
        fetch("rs_a1", 5'd1, 16'h7001);
        fetch("rs_a2", 5'd2, 16'h0000);

        // Asynchronous reset in the middle of a load
        step();
        start_load();
        beat(16'h8000, 1'b0);
        beat(16'h8001, 1'b0);
        beat(16'h8002, 1'b0);
        check("mr_pre_len", prog_len, 3);
        #2 reset = 1'b1;
        #1;
        check("mr_hold", cpu_hold, 0);
        check("mr_ready", load_ready, 0);
        check("mr_len", prog_len, 0);
        fetch("mr_a0", 5'd0, 16'h0000);
        step();
        reset = 1'b0;
        check("mr_done_0", load_done, 0);
        step();
        check("mr_done_1", load_done, 0);
        check("mr_len_after", prog_len, 0);
        fetch("mr_a1", 5'd1, 16'h0000);
        fetch("mr_a2", 5'd2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
